// File: rtl/ref_read_sequencer_pkg.sv
// ref_read_sequencer_pkg: shared accelerator constants, FSM state type and helpers.
//   BEAT_BYTES/PAGE_BYTES size the memory beat and the no-crossing page; DEF_MAX_BURST caps a request.
package ref_read_sequencer_pkg;
    localparam int BEAT_BYTES    = 32;
    localparam int PAGE_BYTES    = 4096;
    localparam int DEF_MAX_BURST = 16;
    localparam int BEAT_SHIFT    = $clog2(BEAT_BYTES);
    localparam int PAGE_SHIFT    = $clog2(PAGE_BYTES);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/ref_read_sequencer_if.sv
// ref_read_sequencer_if: job, read-request, read-data and engine-data signals of the sequencer.
//   master = sequencer side (issues reads, drives engine data); slave = job source, arbiter, memory and engine.
interface ref_read_sequencer_if #(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 6
);
    logic [ADDR_WIDTH-1:0] job_addr_in;
    logic [15:0]           job_beats_in;
    logic [ID_WIDTH-1:0]   job_id_in;
    logic                  job_valid_in;
    logic                  job_rdy_out;
    logic [ID_WIDTH-1:0]   rd_id_out;
    logic [ADDR_WIDTH-1:0] rd_addr_out;
    logic [7:0]            rd_len_out;
    logic                  rd_info_valid_out;
    logic                  rd_info_rdy_in;
    logic [DATA_WIDTH-1:0] rd_data_in;
    logic                  rd_data_valid_in;
    logic                  rd_data_rdy_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid_out;
    logic                  data_last_out;
    logic                  data_rdy_in;
    logic                  done_out;
    modport master (
        input  job_addr_in, job_beats_in, job_id_in, job_valid_in, rd_info_rdy_in,
               rd_data_in, rd_data_valid_in, data_rdy_in,
        output job_rdy_out, rd_id_out, rd_addr_out, rd_len_out, rd_info_valid_out,
               rd_data_rdy_out, data_out, data_valid_out, data_last_out, done_out
    );
    modport slave (
        output job_addr_in, job_beats_in, job_id_in, job_valid_in, rd_info_rdy_in,
               rd_data_in, rd_data_valid_in, data_rdy_in,
        input  job_rdy_out, rd_id_out, rd_addr_out, rd_len_out, rd_info_valid_out,
               rd_data_rdy_out, data_out, data_valid_out, data_last_out, done_out
    );
endinterface

// File: rtl/ref_read_sequencer_burst_len_calc.sv
// burst_len_calc: combinational burst size = min(remaining, MAX_BURST, beats left in the 4 KB page).
//   addr_i: beat index within the current page; rem_i: beats left in the job; burst_o: beats to request.
module burst_len_calc
    import ref_read_sequencer_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic [PAGE_SHIFT-BEAT_SHIFT-1:0] addr_i,
    input  logic [15:0]                      rem_i,
    output logic [15:0]                      burst_o
);
    logic [15:0] page_left;
    assign page_left = 16'(PAGE_BYTES >> BEAT_SHIFT) - 16'(addr_i);
    assign burst_o   = min16(min16(rem_i, 16'(MAX_BURST)), page_left);
endmodule

// File: rtl/ref_read_sequencer.sv
// ref_read_sequencer: splits a job into page-safe read bursts, bounds outstanding beats, streams data to the engine.
//   clk/rst: clock and synchronous active-high reset; bus: master modport carrying job, request, read-data and engine ports.
module ref_read_sequencer
    import ref_read_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH      = 33,
    parameter int DATA_WIDTH      = 256,
    parameter int ID_WIDTH        = 6,
    parameter int MAX_BURST       = DEF_MAX_BURST,
    parameter int MAX_OUTSTANDING = 64
) (
    input logic                  clk,
    input logic                  rst,
    ref_read_sequencer_if.master bus
);
    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, rd_addr_q;
    logic [15:0]           rem_q, beats_q, out_q, cnt_q, burst_q;
    logic [15:0]           burst, out_d, cnt_d, cnt_nx;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q;
    logic                  valid_q, done_q, busy, dvalid, beat, issue_hs, fits;
    burst_len_calc #(.MAX_BURST(MAX_BURST)) u_calc (
        .addr_i (addr_q[PAGE_SHIFT-1:BEAT_SHIFT]),
        .rem_i  (rem_q),
        .burst_o(burst)
    );
    assign busy     = state_q != IDLE;
    assign dvalid   = busy & bus.rd_data_valid_in;
    assign beat     = dvalid & bus.data_rdy_in;
    assign issue_hs = valid_q & bus.rd_info_rdy_in;
    assign fits     = ({1'b0, out_q} + {1'b0, burst}) <= 17'(MAX_OUTSTANDING);
    assign cnt_nx   = cnt_q + 16'd1;
    // Issue and delivery in the same cycle net out to burst - 1.
    assign out_d    = out_q + (issue_hs ? burst_q : 16'd0) - (beat ? 16'd1 : 16'd0);
    assign cnt_d    = beat ? cnt_nx : cnt_q;
    assign bus.job_rdy_out       = state_q == IDLE;
    assign bus.rd_id_out         = id_q;
    assign bus.rd_addr_out       = rd_addr_q;
    assign bus.rd_len_out        = len_q;
    assign bus.rd_info_valid_out = valid_q;
    assign bus.rd_data_rdy_out   = busy & bus.data_rdy_in;
    assign bus.data_out          = busy ? bus.rd_data_in : {DATA_WIDTH{1'b0}};
    assign bus.data_valid_out    = dvalid;
    assign bus.data_last_out     = dvalid & (cnt_nx == beats_q);
    assign bus.done_out          = done_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_addr_q <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
            burst_q   <= '0;
            id_q      <= '0;
            len_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            case (state_q)
                IDLE: if (bus.job_valid_in) begin
                    addr_q  <= bus.job_addr_in;
                    rem_q   <= bus.job_beats_in;
                    beats_q <= bus.job_beats_in;
                    id_q    <= bus.job_id_in;
                    cnt_q   <= '0;
                    done_q  <= bus.job_beats_in == 16'd0;
                    state_q <= (bus.job_beats_in == 16'd0) ? IDLE : ISSUE;
                end
                ISSUE: if (issue_hs) begin
                    valid_q <= 1'b0;
                    addr_q  <= addr_q + (ADDR_WIDTH'(burst_q) << BEAT_SHIFT);
                    rem_q   <= rem_q - burst_q;
                    state_q <= (rem_q == burst_q) ? DRAIN : ISSUE;
                end else if (!valid_q && fits) begin
                    // Payload is frozen here and held until the arbiter accepts it.
                    valid_q   <= 1'b1;
                    rd_addr_q <= addr_q;
                    len_q     <= 8'(burst - 16'd1);
                    burst_q   <= burst;
                end
                DRAIN: if (beat && cnt_nx == beats_q) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
